// File: rtl/accum_buffer_bank.sv
// Purpose: multi-entry read-and-clear signed accumulation buffer with sticky overflow flag.
// Latency: accumulate takes effect at the next edge; a read result appears 1 cycle after rd_en_i.
// Backpressure: none; one write and one read are accepted every cycle.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous clear of all entries and ovf_o (beats write/read)
//   wr_en_i/wr_addr_i/wr_data_i   add sign-extended wr_data_i into entry wr_addr_i
//   rd_en_i/rd_addr_i        read entry rd_addr_i and zero it
//   rd_valid_o/rd_data_o     read result, rd_data_o is '0 when rd_valid_o is low
//   ovf_o                    sticky: some accumulation overflowed ACC_W
// Build option: define ACCUM_BANK_SAT_EN to saturate on overflow instead of wrapping.
module accum_buffer_bank #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [ACC_W-1:0]  rd_data_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] mem_q [DEPTH];
    logic [ACC_W-1:0] mem_d [DEPTH];
    logic             rd_valid_q, rd_valid_d;
    logic [ACC_W-1:0] rd_data_q, rd_data_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] wr_ext;
    logic [ACC_W-1:0] wr_old, rd_old, base, sum, new_val;
    logic             wr_ok, rd_ok, same_entry, ovf_add;

    assign wr_ext = ACC_W'($signed(wr_data_i));

    always_comb begin
        wr_old = '0;
        rd_old = '0;
        wr_ok  = 1'b0;
        rd_ok  = 1'b0;
        // Decode by scanning entries so out-of-range addresses simply match nothing.
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr_i == ADDR_W'(i)) begin
                wr_ok  = 1'b1;
                wr_old = mem_q[i];
            end
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_ok  = 1'b1;
                rd_old = mem_q[i];
            end
        end

        // A read of the entry being written hands out the old total, so the new pass
        // starts from zero plus this datum.
        same_entry = wr_en_i && rd_en_i && wr_ok && rd_ok && (wr_addr_i == rd_addr_i);
        base       = same_entry ? '0 : wr_old;
        sum        = base + wr_ext;
        ovf_add    = (base[ACC_W-1] == wr_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

`ifdef ACCUM_BANK_SAT_EN
        if (ovf_add) begin
            new_val = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            new_val = sum;
        end
`else
        new_val = sum;
`endif

        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_en_i && rd_ok && (rd_addr_i == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end
            if (wr_en_i && wr_ok && (wr_addr_i == ADDR_W'(i))) begin
                mem_d[i] = new_val;
            end
        end
        ovf_d = ovf_q | (wr_en_i && wr_ok && ovf_add);

        // Read result is captured even under clear_i (pre-clear value).
        rd_valid_d = rd_en_i;
        rd_data_d  = (rd_en_i && rd_ok) ? rd_old : '0;

        if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_accum_buffer_bank.sv
// Directed bench for accum_buffer_bank: a DEPTH=16 instance for the main function and a
// DEPTH=12 instance sharing the same stimulus for out-of-range address handling.
module tb_accum_buffer_bank;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        rd_en_i = 1'b0;
    logic [3:0]  rd_addr_i = '0;

    logic        rd_valid_o, ovf_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_12, ovf_12;
    logic [31:0] rd_data_12;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ACCUM_BANK_SAT_EN
    localparam logic [31:0] POS_OVF_EXP = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_OVF_EXP = 32'h8000_0000;
`else
    localparam logic [31:0] POS_OVF_EXP = 32'h8000_0000;
    localparam logic [31:0] NEG_OVF_EXP = 32'h7FFF_FFFF;
`endif

    accum_buffer_bank #(.DATA_W(32), .ACC_W(32), .DEPTH(16)) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en_i),
        .rd_addr_i (rd_addr_i),
        .rd_valid_o(rd_valid_o),
        .rd_data_o (rd_data_o),
        .ovf_o     (ovf_o)
    );

    accum_buffer_bank #(.DATA_W(32), .ACC_W(32), .DEPTH(12)) u_d12 (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_en_i),
        .rd_addr_i (rd_addr_i),
        .rd_valid_o(rd_valid_12),
        .rd_data_o (rd_data_12),
        .ovf_o     (ovf_12)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        rd_en_i = 1'b1; rd_addr_i = a;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic wr_rd(input logic [3:0] wa, input logic [31:0] d, input logic [3:0] ra);
        wr_en_i = 1'b1; wr_addr_i = wa; wr_data_i = d;
        rd_en_i = 1'b1; rd_addr_i = ra;
        tick();
        wr_en_i = 1'b0; rd_en_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", {31'b0, rd_valid_o}, 32'd0);
        check("rst_data", rd_data_o, 32'd0);
        check("rst_ovf", {31'b0, ovf_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        // Accumulate 5 + 7 - 3 into entry 2
        wr(4'd2, 32'd5);
        wr(4'd2, 32'd7);
        wr(4'd2, 32'hFFFF_FFFD);
        rd(4'd2);
        check("acc_valid", {31'b0, rd_valid_o}, 32'd1);
        check("acc_data", rd_data_o, 32'd9);
        tick();
        check("idle_valid", {31'b0, rd_valid_o}, 32'd0);
        check("idle_data", rd_data_o, 32'd0);
        rd(4'd2);
        check("reread_valid", {31'b0, rd_valid_o}, 32'd1);
        check("reread_data", rd_data_o, 32'd0);

        // Same-entry write and read
        wr(4'd4, 32'd10);
        wr_rd(4'd4, 32'd3, 4'd4);
        check("same_old", rd_data_o, 32'd10);
        rd(4'd4);
        check("same_new", rd_data_o, 32'd3);

        // Interleaved traffic on distinct entries
        wr_rd(4'd0, 32'd11, 4'd1);
        check("ilv_e1_a", rd_data_o, 32'd0);
        wr_rd(4'd15, 32'd22, 4'd1);
        check("ilv_e1_b", rd_data_o, 32'd0);
        wr_rd(4'd0, 32'd1, 4'd15);
        check("ilv_e15", rd_data_o, 32'd22);
        rd(4'd0);
        check("ilv_e0", rd_data_o, 32'd12);
        rd(4'd15);
        check("ilv_e15_clr", rd_data_o, 32'd0);

        // Out-of-range address on the 12-entry bank
        wr(4'd11, 32'd100);
        wr_rd(4'd13, 32'd50, 4'd13);
        check("oor_valid", {31'b0, rd_valid_12}, 32'd1);
        check("oor_data", rd_data_12, 32'd0);
        rd(4'd13);
        check("oor_reread", rd_data_12, 32'd0);
        check("d16_e13", rd_data_o, 32'd50);
        rd(4'd11);
        check("oor_e11_kept", rd_data_12, 32'd100);
        check("oor_ovf", {31'b0, ovf_12}, 32'd0);

        // Positive overflow
        wr(4'd3, 32'h7FFF_FFFF);
        check("pre_ovf", {31'b0, ovf_o}, 32'd0);
        wr(4'd3, 32'd1);
        check("ovf_set", {31'b0, ovf_o}, 32'd1);
        rd(4'd3);
        check("ovf_pos_data", rd_data_o, POS_OVF_EXP);
        // Negative overflow
        wr(4'd5, 32'h8000_0000);
        wr(4'd5, 32'hFFFF_FFFF);
        rd(4'd5);
        check("ovf_neg_data", rd_data_o, NEG_OVF_EXP);
        check("ovf_sticky", {31'b0, ovf_o}, 32'd1);

        // Clear with nonzero entries, read issued alongside
        wr(4'd6, 32'd77);
        wr(4'd11, 32'd8);
        clear_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 4'd6;
        wr_en_i = 1'b1; wr_addr_i = 4'd7; wr_data_i = 32'd5;
        tick();
        clear_i = 1'b0; rd_en_i = 1'b0; wr_en_i = 1'b0;
        check("clr_rd_valid", {31'b0, rd_valid_o}, 32'd1);
        check("clr_rd_data", rd_data_o, 32'd77);
        check("clr_ovf", {31'b0, ovf_o}, 32'd0);
        rd(4'd6);
        check("clr_e6", rd_data_o, 32'd0);
        rd(4'd11);
        check("clr_e11", rd_data_o, 32'd0);
        rd(4'd7);
        check("clr_e7_wr_blocked", rd_data_o, 32'd0);

        // Reset mid-accumulation
        wr(4'd8, 32'd9);
        wr(4'd8, 32'd4);
        rd_en_i = 1'b1; rd_addr_i = 4'd8;
        wr_en_i = 1'b1; wr_addr_i = 4'd9; wr_data_i = 32'h8000_0000;
        tick();
        wr(4'd9, 32'h8000_0000);
        check("pre_rst_ovf", {31'b0, ovf_o}, 32'd1);
        rd_en_i = 1'b1; rd_addr_i = 4'd8;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, rd_valid_o}, 32'd0);
        check("mid_rst_data", rd_data_o, 32'd0);
        check("mid_rst_ovf", {31'b0, ovf_o}, 32'd0);
        rd_en_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_valid", {31'b0, rd_valid_o}, 32'd0);
        rd(4'd9);
        check("post_rst_e9", rd_data_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
